// File: rtl/attopu_pkg.sv
// Shared definitions for the attopu core: fetch FSM state encoding,
// next-PC select codes and default datapath widths.
package attopu_pkg;

  localparam int unsigned PC_W_DEFAULT    = 16;
  localparam int unsigned INSTR_W_DEFAULT = 16;
  localparam int unsigned COUNT_W         = 16;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } fetchState_e;

  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_REL = 2'b01;
  localparam logic [1:0] PCSEL_REG = 2'b10;

endpackage

// File: rtl/attopu_pc_next.sv
// Combinational next-PC selection: increment, pc-relative branch, or register jump.
// All arithmetic wraps modulo 2^PC_WIDTH.
module attopu_pc_next
  import attopu_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_W_DEFAULT
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [1:0]          nextPCSel,
  input  logic [PC_WIDTH-1:0] branchAddr,
  input  logic [PC_WIDTH-1:0] regJump,
  output logic [PC_WIDTH-1:0] next_pc
);

  // Both 2'b10 and 2'b11 select the register jump.
  always_comb begin
    next_pc = regJump;
    if (nextPCSel == PCSEL_INC) begin
      next_pc = pc + PC_WIDTH'(1);
    end else if (nextPCSel == PCSEL_REL) begin
      next_pc = pc + branchAddr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC, IR and retired-instruction counter, and runs
// the imem req/ack handshake. Optional halt-on-branch-to-self: ATTOPU_HALT_DETECT_EN.
module fetch_unit
  import attopu_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = PC_W_DEFAULT,
  parameter int unsigned          INSTR_WIDTH = INSTR_W_DEFAULT,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imemReq,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic                   imemAck,
  input  logic [INSTR_WIDTH-1:0] imemRdata,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instrValid,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic                   execStall,
  input  logic [1:0]             nextPCSel,
  input  logic [PC_WIDTH-1:0]    branchAddr,
  input  logic [PC_WIDTH-1:0]    regJump,
  output logic [COUNT_W-1:0]     instrCount,
  output logic                   halted
);

  fetchState_e            state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    pc_d;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [COUNT_W-1:0]     count_q;
  logic                   req_q;
  logic                   valid_q;
  logic                   halt_q;
  logic                   selfBranch;

  attopu_pc_next #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_next (
    .pc         (pc_q),
    .nextPCSel  (nextPCSel),
    .branchAddr (branchAddr),
    .regJump    (regJump),
    .next_pc    (pc_d)
  );

`ifdef ATTOPU_HALT_DETECT_EN
  assign selfBranch = (nextPCSel == PCSEL_REL) && (branchAddr == '0);
`else
  assign selfBranch = 1'b0;
`endif

  // Outputs are registered alongside the state so they change only with it;
  // the async reset clears imemReq immediately, even mid-fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imemAck) begin
            ir_q    <= imemRdata;
            state_q <= ST_EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (!execStall) begin
            pc_q    <= pc_d;
            count_q <= count_q + COUNT_W'(1);
            valid_q <= 1'b0;
            if (selfBranch) begin
              state_q <= ST_HALT;
              halt_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
              req_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_HALT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imemReq     = req_q;
  assign imemAddr    = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;
  assign instrValid  = valid_q;
  assign instrCount  = count_q;
  assign halted      = halt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: handshake timing, next-PC modes,
// stall hold, PC wrap, async reset mid-fetch, and halt detection when enabled.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemRdata;
  logic [15:0] instruction;
  logic        instrValid;
  logic [15:0] pc;
  logic        execStall;
  logic [1:0]  nextPCSel;
  logic [15:0] branchAddr;
  logic [15:0] regJump;
  logic [15:0] instrCount;
  logic        halted;

  int testsRun;
  int testsFailed;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemAck     (imemAck),
    .imemRdata   (imemRdata),
    .instruction (instruction),
    .instrValid  (instrValid),
    .pc          (pc),
    .execStall   (execStall),
    .nextPCSel   (nextPCSel),
    .branchAddr  (branchAddr),
    .regJump     (regJump),
    .instrCount  (instrCount),
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Zero-wait fetch: ack is presented during the FETCH cycle itself.
  task automatic applyStimulus(input logic [15:0] word);
    imemAck   = 1'b1;
    imemRdata = word;
    tick();
    imemAck   = 1'b0;
  endtask

  task automatic execute(input logic [1:0] sel, input logic [15:0] ba,
                         input logic [15:0] rj);
    nextPCSel  = sel;
    branchAddr = ba;
    regJump    = rj;
    tick();
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n      = 1'b0;
    imemAck    = 1'b0;
    imemRdata  = 16'h0000;
    execStall  = 1'b0;
    nextPCSel  = 2'b00;
    branchAddr = 16'h0000;
    regJump    = 16'h0000;

    repeat (2) tick();
    checkOutput("rst_req",   {31'd0, imemReq},    32'd0);
    checkOutput("rst_valid", {31'd0, instrValid}, 32'd0);
    checkOutput("rst_pc",    {16'd0, pc},         32'h0000);
    checkOutput("rst_ir",    {16'd0, instruction}, 32'h0000);
    checkOutput("rst_count", {16'd0, instrCount}, 32'd0);
    checkOutput("rst_halt",  {31'd0, halted},     32'd0);

    rst_n = 1'b1;
    #1;
    checkOutput("boot_req", {31'd0, imemReq}, 32'd0);
    tick();
    checkOutput("fetch_req",  {31'd0, imemReq},  32'd1);
    checkOutput("fetch_addr", {16'd0, imemAddr}, 32'h0000);

    // Two wait cycles before the memory acknowledges.
    repeat (2) tick();
    checkOutput("wait_req",   {31'd0, imemReq},    32'd1);
    checkOutput("wait_valid", {31'd0, instrValid}, 32'd0);
    checkOutput("wait_addr",  {16'd0, imemAddr},   32'h0000);
    applyStimulus(16'h2005);
    checkOutput("exec_ir",    {16'd0, instruction}, 32'h2005);
    checkOutput("exec_valid", {31'd0, instrValid},  32'd1);
    checkOutput("exec_req",   {31'd0, imemReq},     32'd0);
    execute(2'b00, 16'h0000, 16'h0000);
    checkOutput("inc_valid", {31'd0, instrValid}, 32'd0);
    checkOutput("inc_addr",  {16'd0, imemAddr},   32'h0001);
    checkOutput("inc_count", {16'd0, instrCount}, 32'd1);
    checkOutput("inc_req",   {31'd0, imemReq},    32'd1);

    // Negative relative branch from pc=5.
    applyStimulus(16'h1111);
    execute(2'b10, 16'h0000, 16'h0005);
    checkOutput("jmp5_addr", {16'd0, imemAddr}, 32'h0005);
    applyStimulus(16'h2222);
    execute(2'b01, 16'hFFFE, 16'h7777);
    checkOutput("rel_addr",  {16'd0, imemAddr},   32'h0003);
    checkOutput("rel_count", {16'd0, instrCount}, 32'd3);

    applyStimulus(16'h3333);
    execute(2'b10, 16'h0009, 16'h1234);
    checkOutput("reg10_addr", {16'd0, imemAddr}, 32'h1234);
    applyStimulus(16'h4444);
    execute(2'b11, 16'h0009, 16'h4321);
    checkOutput("reg11_addr", {16'd0, imemAddr}, 32'h4321);

    // Stall three cycles with a stray ack and a branch selector that must be ignored.
    applyStimulus(16'hBEEF);
    execStall  = 1'b1;
    nextPCSel  = 2'b01;
    branchAddr = 16'h0007;
    imemAck    = 1'b1;
    imemRdata  = 16'hDEAD;
    repeat (3) tick();
    imemAck    = 1'b0;
    checkOutput("stall_pc",    {16'd0, pc},          32'h4321);
    checkOutput("stall_ir",    {16'd0, instruction}, 32'hBEEF);
    checkOutput("stall_valid", {31'd0, instrValid},  32'd1);
    checkOutput("stall_count", {16'd0, instrCount},  32'd5);
    checkOutput("stall_req",   {31'd0, imemReq},     32'd0);
    execStall = 1'b0;
    execute(2'b00, 16'h0000, 16'h0000);
    checkOutput("resume_addr",  {16'd0, imemAddr},   32'h4322);
    checkOutput("resume_count", {16'd0, instrCount}, 32'd6);
    checkOutput("resume_req",   {31'd0, imemReq},    32'd1);

    // PC wraps from FFFF to 0 on increment.
    applyStimulus(16'h5555);
    execute(2'b10, 16'h0000, 16'hFFFF);
    checkOutput("ffff_addr", {16'd0, imemAddr}, 32'hFFFF);
    applyStimulus(16'h6666);
    execute(2'b00, 16'h0000, 16'h0000);
    checkOutput("wrap_addr",  {16'd0, imemAddr},   32'h0000);
    checkOutput("wrap_count", {16'd0, instrCount}, 32'd8);

    // Move pc away from reset value, then reset in the middle of a fetch.
    applyStimulus(16'h7777);
    execute(2'b10, 16'h0000, 16'h00A0);
    checkOutput("pre_rst_req", {31'd0, imemReq}, 32'd1);
    imemAck   = 1'b1;
    imemRdata = 16'hCAFE;
    rst_n     = 1'b0;
    #1;
    checkOutput("midrst_req",   {31'd0, imemReq},    32'd0);
    checkOutput("midrst_pc",    {16'd0, pc},         32'h0000);
    checkOutput("midrst_count", {16'd0, instrCount}, 32'd0);
    tick();
    imemAck = 1'b0;
    rst_n   = 1'b1;
    checkOutput("midrst_ir", {16'd0, instruction}, 32'h0000);
    tick();
    checkOutput("refetch_req",  {31'd0, imemReq},  32'd1);
    checkOutput("refetch_addr", {16'd0, imemAddr}, 32'h0000);

    // Branch-to-self.
    applyStimulus(16'h8888);
    execute(2'b01, 16'h0000, 16'h0000);
    checkOutput("self_count", {16'd0, instrCount}, 32'd1);
    checkOutput("self_addr",  {16'd0, imemAddr},   32'h0000);
    checkOutput("self_valid", {31'd0, instrValid}, 32'd0);
`ifdef ATTOPU_HALT_DETECT_EN
    checkOutput("halt_flag", {31'd0, halted},  32'd1);
    checkOutput("halt_req",  {31'd0, imemReq}, 32'd0);
    imemAck = 1'b1;
    repeat (3) tick();
    imemAck = 1'b0;
    checkOutput("halt_hold_req",   {31'd0, imemReq},    32'd0);
    checkOutput("halt_hold_flag",  {31'd0, halted},     32'd1);
    checkOutput("halt_hold_valid", {31'd0, instrValid}, 32'd0);
    checkOutput("halt_hold_count", {16'd0, instrCount}, 32'd1);
`else
    checkOutput("nohalt_flag", {31'd0, halted},  32'd0);
    checkOutput("nohalt_req",  {31'd0, imemReq}, 32'd1);
    applyStimulus(16'h8888);
    execute(2'b01, 16'h0000, 16'h0000);
    checkOutput("nohalt_addr",  {16'd0, imemAddr},   32'h0000);
    checkOutput("nohalt_count", {16'd0, instrCount}, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
